// File: rtl/code_conv_pkg.sv
// Shared definitions for the registered code converter: mode codes, FSM states
// and the BCD digit adjust used by the double-dabble step.
package code_conv_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_B2G   = 2'd1;
  localparam logic [1:0] MODE_G2B   = 2'd2;
  localparam logic [1:0] MODE_B2BCD = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digits never exceed 9 before the adjust, so the 4-bit sum cannot wrap.
  function automatic logic [3:0] add3_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One shift-add-3 iteration on the concatenated {BCD, binary} register.
module bcd_dabble_step
  import code_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIGITS = 2,
  localparam int unsigned OUT_W = 4 * DIGITS
) (
  input  logic [OUT_W+WIDTH-1:0] vec_i,
  output logic [OUT_W+WIDTH-1:0] vec_o
);

  logic [OUT_W+WIDTH-1:0] adj;

  always_comb begin
    adj = vec_i;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[WIDTH+4*i +: 4] = add3_digit(vec_i[WIDTH+4*i +: 4]);
    end
    vec_o = {adj[OUT_W+WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/code_conv_seq.sv
// Registered code converter (pass, bin->Gray, Gray->bin, bin->BCD) with
// valid/ready handshakes; BCD takes WIDTH iterations in state CONV.
module code_conv_seq
  import code_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIGITS = 2,
  localparam int unsigned OUT_W = 4 * DIGITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_i,
  input  logic [1:0]       mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  localparam int unsigned SregW = OUT_W + WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SregW-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SregW-1:0] step_out;
  logic [WIDTH-1:0] conv_word;
  logic             accept;

  bcd_dabble_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_step (
    .vec_i (sreg_q),
    .vec_o (step_out)
  );

  // Ready bypass from DONE lets a new word retire the old result on the same edge.
  assign in_ready_o  = (state_q == StIdle) | ((state_q == StDone) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_o       = out_q;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StConv);

  always_comb begin
    case (mode_i)
      MODE_B2G: conv_word = bin2gray(in_i);
      MODE_G2B: conv_word = gray2bin(in_i);
      default:  conv_word = in_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;

    case (state_q)
      StConv: begin
        sreg_d = step_out;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          out_d   = step_out[SregW-1 -: OUT_W];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i && !in_valid_i) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (mode_i == MODE_B2BCD) begin
        sreg_d  = {{OUT_W{1'b0}}, in_i};
        cnt_d   = CntW'(WIDTH);
        state_d = StConv;
      end else begin
        out_d   = OUT_W'(conv_word);
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      out_q   <= '0;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_code_conv_seq.sv
// Directed bench for code_conv_seq at WIDTH=4/DIGITS=2 and WIDTH=8/DIGITS=3.
module tb_code_conv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  in4 = '0;
  logic [1:0]  mode4 = '0;
  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b1, busy4;
  logic [7:0]  out4;

  logic [7:0]  in8 = '0;
  logic [1:0]  mode8 = '0;
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, busy8;
  logic [11:0] out8;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  code_conv_seq #(.WIDTH(4), .DIGITS(2)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in4), .mode_i(mode4), .in_valid_i(iv4),
    .in_ready_o(ir4), .out_o(out4), .out_valid_o(ov4), .out_ready_i(or4), .busy_o(busy4)
  );

  code_conv_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in8), .mode_i(mode8), .in_valid_i(iv8),
    .in_ready_o(ir8), .out_o(out8), .out_valid_o(ov8), .out_ready_i(or8), .busy_o(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] bcd3(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic conv4(input logic [3:0] v, input logic [7:0] exp, input string tag);
    in4 = v; mode4 = 2'd3; iv4 = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(ir4), 32'd1);
    tick();
    iv4 = 1'b0; in4 = ~v; mode4 = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1 chk({tag, "_busy"}, 32'(busy4), 32'd1);
      chk({tag, "_novalid"}, 32'(ov4), 32'd0);
      tick();
    end
    #1 chk({tag, "_valid"}, 32'(ov4), 32'd1);
    chk({tag, "_out"}, 32'(out4), 32'(exp));
    chk({tag, "_idlebusy"}, 32'(busy4), 32'd0);
    tick();
  endtask

  task automatic conv8(input int v, input string tag, input bit full);
    in8 = 8'(v); mode8 = 2'd3; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; in8 = 8'(v) ^ 8'hA5;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (full) chk({tag, "_busy"}, 32'(busy8), 32'd1);
      tick();
    end
    #1 chk({tag, "_valid"}, 32'(ov8), 32'd1);
    chk({tag, "_out"}, 32'(out8), 32'(bcd3(v)));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held low
    tick(); tick();
    #1 chk("rst_out4", 32'(out4), 32'h00);
    chk("rst_valid4", 32'(ov4), 32'd0);
    chk("rst_ready4", 32'(ir4), 32'd1);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_out8", 32'(out8), 32'h000);
    rst_n = 1'b1;
    tick();

    // Back-to-back Gray conversions
    in4 = 4'd12; mode4 = 2'd1; iv4 = 1'b1;
    #1 chk("b2g12_rdy", 32'(ir4), 32'd1);
    tick();
    in4 = 4'd10; mode4 = 2'd2;
    #1 chk("b2g12_out", 32'(out4), 32'h0A);
    chk("b2g12_valid", 32'(ov4), 32'd1);
    chk("g2b10_rdy", 32'(ir4), 32'd1);
    tick();
    in4 = 4'd4; mode4 = 2'd1;
    #1 chk("g2b10_out", 32'(out4), 32'h0C);
    chk("g2b10_valid", 32'(ov4), 32'd1);
    tick();
    iv4 = 1'b0;
    #1 chk("b2g4_out", 32'(out4), 32'h06);
    chk("b2g4_valid", 32'(ov4), 32'd1);
    tick();
    #1 chk("gray_idle_valid", 32'(ov4), 32'd0);
    chk("gray_idle_rdy", 32'(ir4), 32'd1);

    // BCD, 4-bit
    conv4(4'd12, 8'h12, "bcd12");
    conv4(4'd10, 8'h10, "bcd10");
    conv4(4'd4, 8'h04, "bcd4");
    conv4(4'd15, 8'h15, "bcd15");

    // BCD, 8-bit corners then sweep
    conv8(255, "bcd255", 1'b1);
    conv8(0, "bcd0", 1'b1);
    for (int v = 0; v < 256; v++) conv8(v, "sweep", 1'b0);

    // Output stall with a competing word held at the input
    in4 = 4'd9; mode4 = 2'd0; iv4 = 1'b1; or4 = 1'b0;
    tick();
    in4 = 4'd3;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_out", 32'(out4), 32'h09);
      chk("stall_valid", 32'(ov4), 32'd1);
      chk("stall_rdy", 32'(ir4), 32'd0);
      tick();
    end
    or4 = 1'b1;
    #1 chk("unstall_rdy", 32'(ir4), 32'd1);
    tick();
    iv4 = 1'b0;
    #1 chk("unstall_out", 32'(out4), 32'h03);
    chk("unstall_valid", 32'(ov4), 32'd1);
    tick();

    // Reset in the middle of a BCD conversion
    in4 = 4'd12; mode4 = 2'd3; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    #1 chk("midconv_busy", 32'(busy4), 32'd1);
    tick();
    rst_n = 1'b0;
    #1 chk("midrst_out", 32'(out4), 32'h00);
    chk("midrst_valid", 32'(ov4), 32'd0);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_rdy", 32'(ir4), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    conv4(4'd9, 8'h09, "postrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/code_conv_seq.md
# code_conv_seq

Parametrised, registered code converter with valid/ready handshakes on input and output. It supports pass-through, binary→Gray, Gray→binary and multi-cycle binary→BCD (shift-add-3) conversion. It succeeds the lab's fixed 4-bit combinational converter and sits between a switch/register source and a 7-segment or LED display driver.

## Interface
Parameters:
- WIDTH, 4: input code width; legal 2..16.
- DIGITS, 2: BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1.
- OUT_W, 4*DIGITS: derived (localparam), output width; always ≥ WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  input code word.
- mode  input  2  0 pass, 1 bin→Gray, 2 Gray→bin, 3 bin→BCD.
- in_valid  input  1  in/mode valid.
- in_ready  output  1  converter can accept this cycle.
- out  output  OUT_W  result; non-BCD modes are zero-extended from WIDTH bits.
- out_valid  output  1  out holds a result.
- out_ready  input  1  consumer takes out this cycle.
- busy  output  1  high while in state CONV.

## Operation
- State machine: IDLE, CONV, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational bypass, so back-to-back single-cycle results are possible.
- Accept = in_valid & in_ready. On accept, in and mode are latched. Later changes to in or mode are ignored until the next accept.
- Accept with mode 0–2:
  - out is loaded with the converted value: in; in ^ (in>>1); or prefix-XOR from the MSB down, g→b.
  - Next state is DONE.
- Accept with mode 3:
  - The shift register is loaded with {BCD=0, bin=in} and the bit counter is set to WIDTH.
  - Next state is CONV.
- CONV, each cycle:
  - Every BCD digit ≥ 5 gets +3.
  - The whole {BCD,bin} register then shifts left by 1 and the counter decrements.
  - When the counter reaches 0 after the step, out ← BCD field and next state is DONE.
- DONE: out_valid=1. out and out_valid stay stable until out_ready.
  - out_ready & !in_valid → IDLE.
  - out_ready & in_valid → new accept; the next state follows that accept's mode.
- in_valid in CONV is not accepted (in_ready=0). The source holds in_valid.
- out_ready in IDLE or CONV has no effect.
- Width rules:
  - Digit +3 is computed in 4 bits and cannot overflow, because digit ≤ 9 before add.
  - The BCD register is OUT_W bits and the bin register is WIDTH bits.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, out=0, out_valid=0, busy=0, counter=0, in_ready=1 (IDLE).
- Reset mid-CONV or mid-DONE aborts immediately. The pending result is lost and out returns to 0.
- Latency is measured from the accept edge E:
  - Modes 0–2: out_valid high after E, i.e. in cycle E+1.
  - Mode 3: out_valid high in cycle E+1+WIDTH. busy is high in cycles E+1..E+WIDTH.
- Throughput:
  - Modes 0–2: one result per cycle with continuous in_valid and out_ready.
  - Mode 3: one result per WIDTH+1 cycles.
- Output stall: with out_ready=0, out is held bit-stable indefinitely.
- Simultaneous out_ready & in_valid in DONE: the old result retires and the new word is accepted on the same edge. No bubble occurs for modes 0–2.

## Structure
- Package code_conv_pkg holds:
  - localparams MODE_PASS=0, MODE_B2G=1, MODE_G2B=2, MODE_B2BCD=3;
  - state encoding IDLE=0, CONV=1, DONE=2.
- Sub-module bcd_dabble_step (parameters WIDTH, DIGITS) is combinational and performs one add-3-then-shift iteration on the {BCD,bin} vector. It is instantiated once in code_conv_seq.
- Gray conversions are inline functions in code_conv_seq.

## Test plan
- WIDTH=4, DIGITS=2; reset, then hold rst_n=0 → out=0x00, out_valid=0, in_ready=1.
- Gray conversions, out_ready=1:
  - in=12, mode=1 → out=0x0A in cycle E+1.
  - in=10, mode=2 → out=0x0C.
  - in=4, mode=1 → out=0x06.
  - These are accepted back-to-back with out_valid continuously high.
- in=12, mode=3 → busy for 4 cycles, then out=0x12, out_valid in E+5. Then in=10 → 0x10 and in=4 → 0x04.
- WIDTH=8, DIGITS=3:
  - in=255, mode=3 → out=0x255 in E+9.
  - in=0 → out=0x000.
  - Sweep all 256 inputs against a model.
- Stall: mode 0, in=9, out_ready=0 for 5 cycles → out=0x09 is stable and in_ready=0. On raising out_ready together with in_valid (in=3), the word is accepted that edge and out=0x03 next cycle.
- Reset mid-CONV: assert rst_n=0 at E+2 of a mode-3 conversion → out=0, out_valid=0, state IDLE immediately. A new conversion after release is correct.
